// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage : memory-access stage of the 16-bit pipelined RISC core.
//
// Owns the data memory and the stack pointer and holds the MEM/WB pipeline
// register. ALU-only instructions pass through in one cycle. Memory
// instructions (push > pop > load > store) take two cycles: the first edge
// latches the request and writes a bubble, and the BUSY edge performs the
// access and retires the instruction. stall is high while BUSY.
//
// Ports
//   clk, rst          clock (rising edge), synchronous active-high reset
//   inValid           instruction present
//   inPush/inPop/inMemRead/inMemWrite   memory-op flags
//   inRegWrite, inMemOrReg, inDstOrPrivate, inRegDstAddress  WB control
//   inAluData         ALU result, forwarded to aluData
//   inStoreData       store / push data
//   inAddress         load / store address, low ADDR_W bits used
//   stall             stage busy, upstream holds
//   outValid, regWrite, memOrReg, dstOrPrivate, regDstAddress,
//   memData, aluData  MEM/WB register outputs
//   sp                current stack pointer
//   stackErr          stack underflow / overflow flag
//
// Build option
//   STACK_GUARD_EN    when defined, an underflowing pop or overflowing push
//                     is suppressed and flagged on stackErr for one cycle.
//                     When undefined, stackErr is 0 and sp wraps freely.
// ---------------------------------------------------------------------------
module mem_stage #(
  parameter int unsigned         ADDR_W   = 11,
  parameter logic [ADDR_W-1:0]   SP_RESET = 11'h7FF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inValid,
  input  logic              inMemRead,
  input  logic              inMemWrite,
  input  logic              inPush,
  input  logic              inPop,
  input  logic              inRegWrite,
  input  logic              inMemOrReg,
  input  logic              inDstOrPrivate,
  input  logic [3:0]        inRegDstAddress,
  input  logic [15:0]       inAluData,
  input  logic [15:0]       inStoreData,
  input  logic [15:0]       inAddress,
  output logic              stall,
  output logic              outValid,
  output logic              regWrite,
  output logic              memOrReg,
  output logic              dstOrPrivate,
  output logic [3:0]        regDstAddress,
  output logic [15:0]       memData,
  output logic [15:0]       aluData,
  output logic [ADDR_W-1:0] sp,
  output logic              stackErr
);

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic [1:0] {OP_PUSH, OP_POP, OP_LOAD, OP_STORE} op_t;

  state_t            r_state, w_state_next;
  op_t               r_op, w_op;
  logic              w_mem_op;

  // Request fields latched when a memory op is accepted.
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_store_data;
  logic [15:0]       r_alu_lat;
  logic              r_rw_lat, r_mor_lat, r_dop_lat;
  logic [3:0]        r_dst_lat;

  logic [ADDR_W-1:0] r_sp;
  logic [15:0]       r_mem [2**ADDR_W];

  // MEM/WB register.
  logic              r_out_valid, r_reg_write, r_mem_or_reg, r_dst_or_private;
  logic [3:0]        r_reg_dst;
  logic [15:0]       r_mem_data, r_alu_data;
  logic              r_stack_err;

  logic              w_stack_err;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_waddr;
  logic [ADDR_W-1:0] w_pop_addr;
  logic [15:0]       w_rd_data;
  logic              w_unused_addr_bits;

  // Upper address bits are deliberately ignored (word address truncation).
  assign w_unused_addr_bits = ^inAddress[15:ADDR_W];

  // Op decode with fixed priority push > pop > load > store.
  always_comb begin
    w_op     = OP_STORE;
    w_mem_op = inPush | inPop | inMemRead | inMemWrite;
    if (inPush)         w_op = OP_PUSH;
    else if (inPop)     w_op = OP_POP;
    else if (inMemRead) w_op = OP_LOAD;
  end

  // Next-state logic.
  // NOTE: the default assignment first keeps this block latch-free on every path.
  always_comb begin
    w_state_next = r_state;
    if (r_state == IDLE) begin
      if (inValid && w_mem_op) w_state_next = BUSY;
    end else begin
      w_state_next = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  assign stall = (r_state == BUSY);

`ifdef STACK_GUARD_EN
  assign w_stack_err = ((r_op == OP_POP)  && (r_sp == SP_RESET)) ||
                       ((r_op == OP_PUSH) && (r_sp == '0));
`else
  assign w_stack_err = 1'b0;
`endif

  assign w_pop_addr  = r_sp + ADDR_W'(1);
  assign w_mem_waddr = (r_op == OP_PUSH) ? r_sp : r_addr;
  // rst must also block a write that would otherwise land on the BUSY edge.
  assign w_mem_we    = (r_state == BUSY) && !rst && !w_stack_err &&
                       ((r_op == OP_PUSH) || (r_op == OP_STORE));

  always_comb begin
    w_rd_data = '0;
    if (!w_stack_err) begin
      if (r_op == OP_POP)       w_rd_data = r_mem[w_pop_addr];
      else if (r_op == OP_LOAD) w_rd_data = r_mem[r_addr];
    end
  end

  // NOTE: the data memory has no reset; its contents survive rst by design.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_waddr] <= r_store_data;
  end

  // Request latch: only meaningful while BUSY, so it needs no reset.
  always_ff @(posedge clk) begin
    if (r_state == IDLE && inValid && w_mem_op) begin
      r_op         <= w_op;
      r_addr       <= inAddress[ADDR_W-1:0];
      r_store_data <= inStoreData;
      r_alu_lat    <= inAluData;
      r_rw_lat     <= inRegWrite;
      r_mor_lat    <= inMemOrReg;
      r_dop_lat    <= inDstOrPrivate;
      r_dst_lat    <= inRegDstAddress;
    end
  end

  // Stack pointer and MEM/WB register. Every cycle defaults to a bubble and
  // the branches below override it.
  // NOTE: non-blocking assignments throughout, so later overrides win cleanly.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sp             <= SP_RESET;
      r_out_valid      <= 1'b0;
      r_reg_write      <= 1'b0;
      r_mem_or_reg     <= 1'b0;
      r_dst_or_private <= 1'b0;
      r_reg_dst        <= '0;
      r_mem_data       <= '0;
      r_alu_data       <= '0;
      r_stack_err      <= 1'b0;
    end else begin
      r_out_valid      <= 1'b0;
      r_reg_write      <= 1'b0;
      r_mem_or_reg     <= 1'b0;
      r_dst_or_private <= 1'b0;
      r_reg_dst        <= '0;
      r_mem_data       <= '0;
      r_alu_data       <= '0;
      r_stack_err      <= 1'b0;
      if (r_state == IDLE) begin
        if (inValid && !w_mem_op) begin
          r_out_valid      <= 1'b1;
          r_reg_write      <= inRegWrite;
          r_mem_or_reg     <= inMemOrReg;
          r_dst_or_private <= inDstOrPrivate;
          r_reg_dst        <= inRegDstAddress;
          r_alu_data       <= inAluData;
        end
      end else begin
        r_out_valid      <= 1'b1;
        r_reg_write      <= r_rw_lat && !w_stack_err;
        r_mem_or_reg     <= r_mor_lat;
        r_dst_or_private <= r_dop_lat;
        r_reg_dst        <= r_dst_lat;
        r_alu_data       <= r_alu_lat;
        r_mem_data       <= w_rd_data;
        r_stack_err      <= w_stack_err;
        if (!w_stack_err) begin
          if (r_op == OP_PUSH)     r_sp <= r_sp - ADDR_W'(1);
          else if (r_op == OP_POP) r_sp <= w_pop_addr;
        end
      end
    end
  end

  assign outValid      = r_out_valid;
  assign regWrite      = r_reg_write;
  assign memOrReg      = r_mem_or_reg;
  assign dstOrPrivate  = r_dst_or_private;
  assign regDstAddress = r_reg_dst;
  assign memData       = r_mem_data;
  assign aluData       = r_alu_data;
  assign sp            = r_sp;
  assign stackErr      = r_stack_err;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 16-bit pipelined RISC core, sitting between execute and write-back.
- Owns the data memory and the stack pointer; performs load, store, push and pop.
- Contains the MEM/WB pipeline register whose outputs drive the write-back stage: regWrite, memOrReg, dstOrPrivate, regDstAddress, memData, aluData.
- Memory ops are multi-cycle and stall upstream; ALU-only ops pass through in one cycle.

Parameters:
- ADDR_W, 11, data-memory word-address width (2^ADDR_W 16-bit words).
- SP_RESET, 11'h7FF, stack pointer value after reset (empty stack).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- inValid  in  1  an instruction is presented this cycle.
- inMemRead  in  1  load: read mem[inAddress].
- inMemWrite  in  1  store: write inStoreData to mem[inAddress].
- inPush  in  1  push inStoreData onto the stack.
- inPop  in  1  pop the stack top into memData.
- inRegWrite  in  1  passed to regWrite.
- inMemOrReg  in  1  passed to memOrReg (1 = memory data).
- inDstOrPrivate  in  1  passed to dstOrPrivate.
- inRegDstAddress  in  4  passed to regDstAddress.
- inAluData  in  16  ALU result, passed to aluData.
- inStoreData  in  16  store/push data.
- inAddress  in  16  load/store address; only bits [ADDR_W-1:0] are used.
- stall  out  1  stage busy; upstream must hold its outputs.
- outValid  out  1  MEM/WB register holds a valid instruction.
- regWrite, memOrReg, dstOrPrivate  out  1 each  MEM/WB control outputs.
- regDstAddress  out  4  MEM/WB destination register.
- memData  out  16  loaded/popped word, 0 otherwise.
- aluData  out  16  registered inAluData.
- sp  out  ADDR_W  current stack pointer.
- stackErr  out  1  stack underflow/overflow indication (see Optional Feature).

Behaviour:
- Reset, synchronous on rst=1 at a rising edge:
  - state=IDLE, sp=SP_RESET.
  - All MEM/WB outputs, outValid and stackErr are 0.
  - Memory contents are not cleared.
  - rst overrides everything, including a BUSY access: no memory write happens and SP takes SP_RESET.
- FSM states: IDLE, BUSY. stall = (state==BUSY), driven combinationally from the state register.
- Op decode: memOp = inPush|inPop|inMemRead|inMemWrite. If several flags are set, priority is push > pop > read > write.
- IDLE with inValid=1 and memOp=0:
  - Next edge loads the MEM/WB register from the inputs, with memData=0 and outValid=1.
  - Latency 1 cycle; no stall.
- IDLE with inValid=1 and memOp=1:
  - Next edge latches the request and control fields, sets state=BUSY, and writes a bubble (outValid=0, regWrite=0, other MEM/WB outputs 0).
- BUSY:
  - Inputs are ignored; upstream holds the next instruction.
  - Next edge performs the access, loads the MEM/WB register with the latched fields and outValid=1, and returns to IDLE.
  - Memory-op latency is 2 cycles; stall is high for exactly 1 cycle.
- Access semantics at the BUSY edge:
  - Push: mem[sp] <= data; sp <= sp-1.
  - Pop: memData <= mem[sp+1]; sp <= sp+1.
  - Load: memData <= mem[addr].
  - Store: mem[addr] <= data; memData=0.
  - SP arithmetic wraps modulo 2^ADDR_W.
- IDLE with inValid=0: next edge writes a bubble; state stays IDLE.
- Control fields (regWrite etc.) are forwarded unmodified; this stage does not interpret them.
- A write and a subsequent read of the same address in back-to-back instructions return the new data: the write completes before the read's BUSY edge.

Optional Feature:
- Macro STACK_GUARD_EN.
- Defined:
  - A pop with sp==SP_RESET (underflow) or a push with sp==0 (overflow) performs no memory access and leaves sp unchanged.
  - The resulting MEM/WB entry has regWrite=0, memData=0, outValid=1, and stackErr=1 for that one cycle.
  - stackErr is 0 at all other times.
- Undefined: stackErr is tied to 0 and SP wraps freely.

Test Plan:
- ALU pass-through: after reset, inValid=1, inRegWrite=1, inMemOrReg=0, inRegDstAddress=3, inAluData=16'h1234 → one cycle later outValid=1, regWrite=1, regDstAddress=3, aluData=16'h1234, memData=0, stall never high.
- Store then load: store 16'hBEEF to address 16'h0010, then load 0x0010 with inMemOrReg=1 → stall high 1 cycle per op; load's memData=16'hBEEF two cycles after issue, with a bubble (outValid=0) in between.
- Push/pop: push 16'hAAAA, push 16'h5555 → sp=0x7FD. Pop twice → memData 16'h5555 then 16'hAAAA, sp back to 0x7FF.
- Address truncation: store 16'h0001 to inAddress=16'hF805, then load 16'h0005 → memData=16'h0001.
- Reset mid-access: store issued, rst=1 on the BUSY edge → state IDLE, outValid=0, sp=0x7FF; a later load of that address returns the pre-store contents.
- STACK_GUARD_EN: pop right after reset → stackErr=1 for one cycle, regWrite=0, sp stays 0x7FF. Without the macro → sp wraps to 0x000 and stackErr=0.
